// File: rtl/div_16x8_seq.sv
// Sequential 16/8 unsigned restoring divider, one quotient bit per cycle.
// Ports: clk, rst, in_valid/in_ready + R[15:0], B[7:0] in; out_valid/out_ready + Q, REM, OVF, DZ out.
module div_16x8_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] R,
  input  logic [7:0]  B,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  Q,
  output logic [7:0]  REM,
  output logic        OVF,
  output logic        DZ
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  state_e     state_q;
  logic [7:0] p_q;
  logic [7:0] s_q;
  logic [7:0] b_q;
  logic [2:0] cnt_q;
  logic       rdy_q;
  logic       vld_q;
  logic [7:0] q_q;
  logic [7:0] rem_q;
  logic       ovf_q;
  logic       dz_q;

  logic [8:0] t_d;
  logic       qbit_d;
  logic [7:0] p_d;

  // P < B holds before each step, so the 8-bit difference is exact.
  always_comb begin
    t_d    = {p_q, s_q[7]};
    qbit_d = (t_d >= {1'b0, b_q});
    p_d    = qbit_d ? (t_d[7:0] - b_q) : t_d[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      p_q     <= '0;
      s_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      rdy_q   <= 1'b1;
      vld_q   <= 1'b0;
      q_q     <= '0;
      rem_q   <= '0;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            rdy_q <= 1'b0;
            b_q   <= B;
            if (B == 8'h00) begin
              state_q <= DONE;
              vld_q   <= 1'b1;
              dz_q    <= 1'b1;
              ovf_q   <= 1'b0;
              q_q     <= 8'hFF;
              rem_q   <= R[7:0];
            end else if (R[15:8] >= B) begin
              state_q <= DONE;
              vld_q   <= 1'b1;
              dz_q    <= 1'b0;
              ovf_q   <= 1'b1;
              q_q     <= 8'hFF;
              rem_q   <= 8'h00;
            end else begin
              state_q <= CALC;
              p_q     <= R[15:8];
              s_q     <= R[7:0];
              cnt_q   <= 3'd0;
            end
          end
        end
        CALC: begin
          p_q   <= p_d;
          s_q   <= {s_q[6:0], 1'b0};
          q_q   <= {q_q[6:0], qbit_d};
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            state_q <= DONE;
            vld_q   <= 1'b1;
            rem_q   <= p_d;
            ovf_q   <= 1'b0;
            dz_q    <= 1'b0;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
            vld_q   <= 1'b0;
            rdy_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          vld_q   <= 1'b0;
          rdy_q   <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = rdy_q;
  assign out_valid = vld_q;
  assign Q         = q_q;
  assign REM       = rem_q;
  assign OVF       = ovf_q;
  assign DZ        = dz_q;

endmodule

// File: tb/tb_div_16x8_seq.sv
// Directed bench for div_16x8_seq.
// Checks results, latency, backpressure and async reset.
module tb_div_16x8_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] R;
  logic [7:0]  B;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  Q;
  logic [7:0]  REM;
  logic        OVF;
  logic        DZ;

  int checks = 0;
  int failures = 0;

  div_16x8_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .R         (R),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Q         (Q),
    .REM       (REM),
    .OVF       (OVF),
    .DZ        (DZ)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst)
      chk("rdy_vld_excl", {31'd0, in_ready & out_valid}, 32'd0);
  end

  task automatic do_op(input logic [15:0] r, input logic [7:0] b,
                       output int lat);
    @(negedge clk);
    R = r;
    B = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic ack();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_vld"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_q"}, {24'd0, Q}, 32'd0);
    chk({tag, "_rem"}, {24'd0, REM}, 32'd0);
    chk({tag, "_flags"}, {30'd0, OVF, DZ}, 32'd0);
  endtask

  int lat;
  logic [7:0] qs;
  logic [7:0] as [11] = '{8'd1, 8'd2, 8'd3, 8'd5, 8'd16, 8'd100,
                          8'd127, 8'd128, 8'd200, 8'd254, 8'd255};
  logic [7:0] bs [13] = '{8'd1, 8'd2, 8'd3, 8'd7, 8'd15, 8'd16, 8'd100,
                          8'd127, 8'd128, 8'd129, 8'd200, 8'd254, 8'd255};

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    R = '0;
    B = '0;
    #1 chk_reset("rst0");
    repeat (2) @(posedge clk);
    #1 chk_reset("rst1");
    @(negedge clk);
    rst = 1'b0;

    // Nominal 12345 / 123
    do_op(16'h3039, 8'h7B, lat);
    chk("nom_lat", lat, 8);
    chk("nom_q", {24'd0, Q}, 32'h64);
    chk("nom_rem", {24'd0, REM}, 32'h2D);
    chk("nom_flags", {30'd0, OVF, DZ}, 32'd0);
    ack();
    chk("nom_ack_vld", {31'd0, out_valid}, 32'd0);
    chk("nom_ack_rdy", {31'd0, in_ready}, 32'd1);

    // Largest in-range quotient
    do_op(16'hFEFF, 8'hFF, lat);
    chk("max_lat", lat, 8);
    chk("max_q", {24'd0, Q}, 32'hFF);
    chk("max_rem", {24'd0, REM}, 32'hFE);
    chk("max_ovf", {31'd0, OVF}, 32'd0);
    ack();

    // Overflow fast path
    do_op(16'h1000, 8'h10, lat);
    chk("ovf_lat", lat, 0);
    chk("ovf_q", {24'd0, Q}, 32'hFF);
    chk("ovf_rem", {24'd0, REM}, 32'h00);
    chk("ovf_flags", {30'd0, OVF, DZ}, 32'b10);
    ack();

    // Divide-by-zero fast path
    do_op(16'h12AB, 8'h00, lat);
    chk("dz_lat", lat, 0);
    chk("dz_q", {24'd0, Q}, 32'hFF);
    chk("dz_rem", {24'd0, REM}, 32'hAB);
    chk("dz_flags", {30'd0, OVF, DZ}, 32'b01);
    ack();

    // Multiplier inverse over a grid of operands
    foreach (as[i]) begin
      foreach (bs[j]) begin
        do_op(16'(as[i] * bs[j]), bs[j], lat);
        chk("inv", {16'd0, Q, REM}, {16'd0, as[i], 8'h00});
        ack();
      end
    end

    // Random in-range dividends
    for (int k = 0; k < 60; k++) begin
      int b, hi, lo, r;
      b = $urandom_range(255, 1);
      hi = $urandom_range(b - 1, 0);
      lo = $urandom_range(255, 0);
      r = hi * 256 + lo;
      do_op(16'(r), 8'(b), lat);
      chk("rnd_id", Q * b + REM, r);
      chk("rnd_lt", {31'd0, int'(REM) < b}, 32'd1);
      ack();
    end

    // Backpressure; stray in_valid during CALC/DONE must be ignored
    @(negedge clk);
    R = 16'h0064;
    B = 8'h07;
    in_valid = 1'b1;
    @(posedge clk);
    #1 R = 16'h12AB;
    B = 8'h00;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("bp_lat", lat, 8);
    chk("bp_res", {16'd0, Q, REM}, 32'h0E02);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      chk("bp_hold_vld", {31'd0, out_valid}, 32'd1);
      chk("bp_hold_res", {14'd0, OVF, DZ, Q, REM}, 32'h0E02);
      chk("bp_hold_rdy", {31'd0, in_ready}, 32'd0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    ack();
    chk("bp_rdy", {31'd0, in_ready}, 32'd1);
    chk("bp_keep", {16'd0, Q, REM}, 32'h0E02);
    @(posedge clk);
    #1 chk("bp_idle", {31'd0, in_ready}, 32'd1);

    // Async reset at CALC step 4
    @(negedge clk);
    R = 16'h3039;
    B = 8'h7B;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1 chk_reset("mid");
    @(posedge clk);
    #1 chk_reset("mid_hold");
    @(negedge clk);
    rst = 1'b0;
    do_op(16'h0064, 8'h0A, lat);
    chk("post_lat", lat, 8);
    chk("post_res", {14'd0, OVF, DZ, Q, REM}, 32'h0A00);
    ack();
    qs = Q;
    chk("post_keep", {24'd0, qs}, 32'h0A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
